// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit holding the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes
// for 32 cycles, then a single fix-up cycle that applies signs and writes HI/LO.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;          // raw dividend, needed for the zero-divisor HI value
  logic [31:0] d_q, d_d;          // multiplicand / divisor magnitude
  logic [63:0] p_q, p_d;          // {acc/remainder, multiplier/quotient}
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        in_signed;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic        op_signed, op_is_div;
  logic [63:0] prod_res;
  logic [31:0] quo_res, rem_res;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StFix) && !flush;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand capture and per-step datapath
  always_comb begin
    accept    = (state_q == StIdle) && start && !flush;
    in_signed = ~md_op[0];
    mag_a     = (in_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b     = (in_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

    // Shift-add: add multiplicand to upper half when multiplier LSB set, shift right
    mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, d_q} : 33'd0);
    mul_next  = {mul_sum, p_q[31:1]};

    // Restoring division: shift next dividend bit into remainder, try subtract
    div_shift = {p_q[63:32], p_q[31]};
    div_trial = {1'b0, div_shift} - {2'b00, d_q};
    if (!div_trial[33]) begin
      div_next = {div_trial[31:0], p_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], p_q[30:0], 1'b0};
    end

    // Sign correction applied in the fix-up cycle
    op_signed = ~op_q[0];
    op_is_div = op_q[1];
    prod_res  = (op_signed && (neg_a_q ^ neg_b_q)) ? (~p_q + 64'd1) : p_q;
    quo_res   = (op_signed && (neg_a_q ^ neg_b_q)) ? (~p_q[31:0] + 32'd1) : p_q[31:0];
    rem_res   = (op_signed && neg_a_q) ? (~p_q[63:32] + 32'd1) : p_q[63:32];
  end

  // Next-state: FSM, iteration counter, operand latches and HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    d_d     = d_q;
    p_d     = p_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          state_d = StCalc;
          cnt_d   = 6'd0;
          op_d    = md_op;
          a_d     = src_a;
          d_d     = mag_b;
          p_d     = {32'd0, mag_a};
          neg_a_d = src_a[31];
          neg_b_d = src_b[31];
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 6'd0;
        end else begin
          p_d   = op_is_div ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        cnt_d   = 6'd0;
        if (!flush) begin
          if (!op_is_div) begin
            hi_d = prod_res[63:32];
            lo_d = prod_res[31:0];
          end else if (d_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_res;
            lo_d = quo_res;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      d_q     <= 32'd0;
      p_q     <= 64'd0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      d_q     <= d_d;
      p_q     <= p_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, sq, sr, sp;
    logic [63:0] up;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin sp = sa * sb; return sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; return up; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = a / b;
        ur = a % b;
        return {ur, uq};
      end
    endcase
  endfunction

  task automatic write_hilo(input logic whi, input logic wlo, input logic [31:0] d);
    @(negedge clk);
    hi_we = whi; lo_we = wlo; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Run one op; optionally disturb with start/mthi/mtlo mid-operation, or
  // coincide an mthi/mtlo write with the accepted start.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit coincide);
    logic [63:0] exp;
    int busy_cnt, done_at, done_cnt;
    exp = model(op, a, b);
    @(negedge clk);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    if (coincide) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    src_a = $urandom; src_b = $urandom; md_op = 2'($urandom_range(0, 3));
    busy_cnt = 0; done_at = 0; done_cnt = 0;
    for (int j = 1; j <= 40; j++) begin
      if (busy) busy_cnt++;
      if (done) begin done_at = j; done_cnt++; end
      if (disturb && j == 5) begin
        start = 1'b1; src_a = $urandom; src_b = $urandom;
        hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      if (disturb && j == 6) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, "_done_cycle"}, 32'(done_at), 32'd33);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_hi"}, hi, exp[63:32]);
    check({tag, "_lo"}, lo, exp[31:0]);
  endtask

  initial begin
    int done_cnt;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; md_op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // HI/LO writes in idle, both together
    write_hilo(1'b1, 1'b1, 32'hCAFE_0001);
    check("mthilo_hi", hi, 32'hCAFE_0001);
    check("mthilo_lo", lo, 32'hCAFE_0001);
    write_hilo(1'b0, 1'b1, 32'h0000_0042);
    check("mtlo_hi", hi, 32'hCAFE_0001);
    check("mtlo_lo", lo, 32'h0000_0042);

    // Directed corner cases
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    check("multu_max_lo_const", lo, 32'h0000_0001);
    run_op("mult_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("mult_neg3x5_lo_const", lo, 32'hFFFF_FFF1);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_neg7_2_lo_const", lo, 32'hFFFF_FFFD);
    check("div_neg7_2_hi_const", hi, 32'hFFFF_FFFF);
    run_op("divu_by0", 2'b11, 32'd10, 32'd0, 1'b0, 1'b0);
    check("divu_by0_hi_const", hi, 32'h0000_000A);
    run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0000_0000);
    run_op("mult_busy_ignore", 2'b00, 32'h0001_2345, 32'hFFFF_8001, 1'b1, 1'b0);
    run_op("div_start_and_mt", 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFF3, 1'b0, 1'b1);

    // Flush in CALC cycle 10
    write_hilo(1'b1, 1'b0, 32'h0000_1234);
    write_hilo(1'b0, 1'b1, 32'h0000_5678);
    @(negedge clk);
    start = 1'b1; md_op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int j = 1; j < 10; j++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    for (int j = 0; j < 40; j++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("flush_done_pulses", 32'(done_cnt), 32'd0);
    check("flush_hi", hi, 32'h0000_1234);
    check("flush_lo", lo, 32'h0000_5678);

    // Start with flush in idle must be ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = 2'b01; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_start_busy", 32'(busy), 32'd0);

    // Asynchronous reset in CALC cycle 5
    write_hilo(1'b1, 1'b1, 32'h0000_AAAA);
    @(negedge clk);
    start = 1'b1; md_op = 2'b01; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j < 5; j++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (done || busy) done_cnt++;
      @(negedge clk);
    end
    check("arst_no_writeback", 32'(done_cnt), 32'd0);
    check("arst_hi_after", hi, 32'd0);
    check("arst_lo_after", lo, 32'd0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
